// File: rtl/msdap_pkg.sv
// Shared constants and types for the MSDAP serial input receiver.
package msdap_pkg;

    // Default configuration: 16-bit words per channel.
    localparam int DEF_WORD_W   = 16;
    // Number of consecutive all-zero word pairs that signal sleep.
    localparam int DEF_ZERO_RUN = 800;
    // Width of the zero-run counter. It must be able to hold DEF_ZERO_RUN.
    localparam int DEF_ZCNT_W   = 10;

    // Receiver states. IDLE waits for a word start. SHIFT collects the remaining bits.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } s2p_state_e;

    // One parallel word for a single channel.
    typedef logic [DEF_WORD_W-1:0] word_t;

endpackage

// File: rtl/msdap_s2p_rx_if.sv
// Serial input / parallel output bundle of the MSDAP serial receiver.
// The master side drives the framed serial stream and reads the parallel words.
// The slave side is the receiver.
interface msdap_s2p_rx_if #(
    parameter int WORD_W = msdap_pkg::DEF_WORD_W
);
    logic              in_ready;
    logic              frame;
    logic              in_l;
    logic              in_r;
    logic [WORD_W-1:0] word_l;
    logic [WORD_W-1:0] word_r;
    logic              s2p_done;
    logic              frame_err;
    logic              all_zeros;

    modport master (
        output in_ready, frame, in_l, in_r,
        input  word_l, word_r, s2p_done, frame_err, all_zeros
    );

    modport slave (
        input  in_ready, frame, in_l, in_r,
        output word_l, word_r, s2p_done, frame_err, all_zeros
    );
endinterface

// File: rtl/msdap_zero_detect.sv
// Counts consecutive all-zero word pairs and flags a run of ZERO_RUN of them.
// all_zeros is registered, and it updates on the same edge that loads the word pair.
module msdap_zero_detect
    import msdap_pkg::*;
#(
    parameter int ZERO_RUN = DEF_ZERO_RUN,
    parameter int ZCNT_W   = DEF_ZCNT_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic word_valid,
    input  logic is_zero,
    output logic all_zeros
);

    localparam logic [ZCNT_W-1:0] ZMAX = ZCNT_W'(ZERO_RUN);

    logic [ZCNT_W-1:0] zcnt_q, zcnt_d;
    logic              all_zeros_q, all_zeros_d;

    // Saturating run counter. Any pair with a nonzero channel restarts the run.
    always_comb begin
        zcnt_d = zcnt_q;
        if (word_valid) begin
            if (is_zero) begin
                zcnt_d = (zcnt_q == ZMAX) ? zcnt_q : zcnt_q + 1'b1;
            end else begin
                zcnt_d = '0;
            end
        end
        all_zeros_d = (zcnt_d == ZMAX);
    end

    // Register the counter and the flag. Reset and clear have the same effect.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            zcnt_q      <= '0;
            all_zeros_q <= 1'b0;
        end else begin
            zcnt_q      <= zcnt_d;
            all_zeros_q <= all_zeros_d;
        end
    end

    assign all_zeros = all_zeros_q;

endmodule

// File: rtl/msdap_s2p_rx.sv
// Dual-channel, MSB-first serial-to-parallel receiver for the MSDAP datapath.
// A frame pulse (qualified by in_ready) marks the MSB of each word.
// A frame that arrives mid-word resynchronises the receiver and pulses frame_err.
// Build option: define S2P_ZERO_DETECT_EN to include the all-zero sleep detector.
// Without it, all_zeros is tied low.
module msdap_s2p_rx
    import msdap_pkg::*;
#(
    parameter int WORD_W   = DEF_WORD_W,
    parameter int ZERO_RUN = DEF_ZERO_RUN,
    parameter int ZCNT_W   = DEF_ZCNT_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 s2p_clear,
    msdap_s2p_rx_if.slave        s2p
);

    localparam int                CNT_W    = $clog2(WORD_W);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD_W - 1);

    s2p_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] sh_l_q, sh_l_d;
    logic [WORD_W-1:0] sh_r_q, sh_r_d;
    logic [WORD_W-1:0] word_l_q, word_l_d;
    logic [WORD_W-1:0] word_r_q, word_r_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              start;

    assign start = s2p.frame && s2p.in_ready;

    // Next-state logic: word start, bit shifting, resync and word completion.
    // A qualified frame inside a word, including on the last-bit edge, is a resync.
    // The partial word is dropped and the current bit becomes the new MSB.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_l_d   = sh_l_q;
        sh_r_d   = sh_r_q;
        word_l_d = word_l_q;
        word_r_d = word_r_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sh_l_d  = {{(WORD_W-1){1'b0}}, s2p.in_l};
                    sh_r_d  = {{(WORD_W-1){1'b0}}, s2p.in_r};
                    cnt_d   = CNT_W'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (start) begin
                    err_d  = 1'b1;
                    sh_l_d = {{(WORD_W-1){1'b0}}, s2p.in_l};
                    sh_r_d = {{(WORD_W-1){1'b0}}, s2p.in_r};
                    cnt_d  = CNT_W'(1);
                end else if (cnt_q == LAST_BIT) begin
                    sh_l_d   = {sh_l_q[WORD_W-2:0], s2p.in_l};
                    sh_r_d   = {sh_r_q[WORD_W-2:0], s2p.in_r};
                    word_l_d = {sh_l_q[WORD_W-2:0], s2p.in_l};
                    word_r_d = {sh_r_q[WORD_W-2:0], s2p.in_r};
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else begin
                    sh_l_d = {sh_l_q[WORD_W-2:0], s2p.in_l};
                    sh_r_d = {sh_r_q[WORD_W-2:0], s2p.in_r};
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Receiver state and registered outputs. reset_n and s2p_clear both clear everything.
    always_ff @(posedge clk) begin
        if (!reset_n || s2p_clear) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sh_l_q   <= '0;
            sh_r_q   <= '0;
            word_l_q <= '0;
            word_r_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_l_q   <= sh_l_d;
            sh_r_q   <= sh_r_d;
            word_l_q <= word_l_d;
            word_r_q <= word_r_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign s2p.word_l    = word_l_q;
    assign s2p.word_r    = word_r_q;
    assign s2p.s2p_done  = done_q;
    assign s2p.frame_err = err_q;

`ifdef S2P_ZERO_DETECT_EN
    // The detector sees the pair being loaded, so all_zeros moves together with the words.
    logic pair_is_zero;
    assign pair_is_zero = (word_l_d == '0) && (word_r_d == '0);

    msdap_zero_detect #(
        .ZERO_RUN (ZERO_RUN),
        .ZCNT_W   (ZCNT_W)
    ) u_zero_detect (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (s2p_clear),
        .word_valid (done_d),
        .is_zero    (pair_is_zero),
        .all_zeros  (s2p.all_zeros)
    );
`else
    assign s2p.all_zeros = 1'b0;
`endif

endmodule
